// File: rtl/prime_pkg.sv
// -----------------------------------------------------------------------------
// prime_pkg
// Shared definitions for the prime sweep controller:
//   - state_t : sweep sequencer state encoding
//   - DEF_W / DEF_SUM_W : default candidate and accumulator widths
// No ports (package).
// -----------------------------------------------------------------------------
package prime_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        ACCUM = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int DEF_W     = 32;
    localparam int DEF_SUM_W = 64;

endpackage

// File: rtl/prime_sweep_ctrl_if.sv
// -----------------------------------------------------------------------------
// prime_sweep_ctrl_if
// Request/result bundle between a problem top (master) and the sweep
// controller (slave).
//   start       : request pulse (master -> slave)
//   limit, kth  : sweep bound and 1-based prime index, captured on accept
//   busy, done  : sweep in progress / results valid
//   prime_count, prime_sum, kth_prime, kth_found : sweep results
// -----------------------------------------------------------------------------
interface prime_sweep_ctrl_if #(
    parameter int W     = prime_pkg::DEF_W,
    parameter int SUM_W = prime_pkg::DEF_SUM_W
);
    logic             start;
    logic [W-1:0]     limit;
    logic [W-1:0]     kth;
    logic             busy;
    logic             done;
    logic [W-1:0]     prime_count;
    logic [SUM_W-1:0] prime_sum;
    logic [W-1:0]     kth_prime;
    logic             kth_found;

    modport master (
        output start, limit, kth,
        input  busy, done, prime_count, prime_sum, kth_prime, kth_found
    );

    modport slave (
        input  start, limit, kth,
        output busy, done, prime_count, prime_sum, kth_prime, kth_found
    );
endinterface

// File: rtl/is_prime.sv
// -----------------------------------------------------------------------------
// is_prime
// Trial-division primality tester. A new test begins on each low-to-high edge
// of start; value is sampled on that edge. done drops on the edge and rises
// once result is valid, then holds until the next start edge.
// This block deliberately has no reset: every test is restarted from scratch
// by the start edge, so nothing stale can leak into a new result.
//   clk    : clock
//   start  : test request, edge-triggered
//   value  : candidate, sampled on the start edge
//   done   : result valid (level)
//   result : 1 when the candidate is prime
// -----------------------------------------------------------------------------
module is_prime #(
    parameter int W = prime_pkg::DEF_W
) (
    input  logic         clk,
    input  logic         start,
    input  logic [W-1:0] value,
    output logic         done,
    output logic         result
);
    logic [W-1:0]   n;
    logic [W-1:0]   d;
    logic           start_q;
    logic           active;
    logic [2*W-1:0] d_sq;

    assign d_sq = {{W{1'b0}}, d} * {{W{1'b0}}, d};

    // Divide by d = 2, 3, 4, ... until d*d exceeds n (prime) or d divides n.
    always_ff @(posedge clk) begin
        start_q <= start;
        if (start && !start_q) begin
            n      <= value;
            d      <= W'(2);
            done   <= 1'b0;
            result <= 1'b0;
            active <= 1'b1;
        end else if (active) begin
            if (n < W'(2)) begin
                done   <= 1'b1;
                result <= 1'b0;
                active <= 1'b0;
            end else if (d_sq > {{W{1'b0}}, n}) begin
                done   <= 1'b1;
                result <= 1'b1;
                active <= 1'b0;
            end else if ((n % d) == '0) begin
                done   <= 1'b1;
                result <= 1'b0;
                active <= 1'b0;
            end else begin
                d <= d + W'(1);
            end
        end
    end
endmodule

// File: rtl/prime_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// prime_sweep_ctrl
// Sweeps candidates 2..limit-1 through one is_prime tester and accumulates
// the prime count, the prime sum and (optionally) the K-th prime found.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : prime_sweep_ctrl_if.slave (start/limit/kth in, results out)
// Build option: PRIME_SWEEP_ODD_SKIP_EN -- after candidate 2, only odd
// candidates are issued (3, 5, 7, ...). Results are unchanged.
// -----------------------------------------------------------------------------
module prime_sweep_ctrl
    import prime_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int SUM_W = DEF_SUM_W
) (
    input  logic              clk,
    input  logic              rst_n,
    prime_sweep_ctrl_if.slave bus
);
    state_t           state, state_next;
    logic [W-1:0]     cand, cand_d;
    logic [W-1:0]     lim, kth_q;
    logic [W:0]       cand_inc;
    logic [1:0]       step;
    logic [W-1:0]     count_inc;
    logic             accept;

    logic             busy_q, done_q, kth_found_q;
    logic [W-1:0]     count_q, kth_prime_q;
    logic [SUM_W-1:0] sum_q;

    logic             t_start;
    logic [W-1:0]     t_value;
    logic             t_done, t_result;

    is_prime #(.W(W)) u_tester (
        .clk    (clk),
        .start  (t_start),
        .value  (t_value),
        .done   (t_done),
        .result (t_result)
    );

    // Candidate stepping. The increment is one bit wider than cand so the
    // end-of-sweep compare works even when limit is the largest W-bit value.
    always_comb begin
`ifdef PRIME_SWEEP_ODD_SKIP_EN
        step = (cand == W'(2)) ? 2'd1 : 2'd2;
`else
        step = 2'd1;
`endif
        cand_inc  = {1'b0, cand} + (W+1)'(step);
        count_inc = count_q + W'(1);
    end

    // Next-state logic and the next candidate value.
    always_comb begin
        state_next = state;
        cand_d     = cand;
        accept     = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    cand_d     = W'(2);
                    state_next = (bus.limit <= W'(2)) ? DONE : ISSUE;
                end
            end
            ISSUE: state_next = WAIT;
            WAIT: begin
                if (t_done) begin
                    state_next = ACCUM;
                end
            end
            ACCUM: begin
                cand_d     = cand_inc[W-1:0];
                state_next = (cand_inc >= {1'b0, lim}) ? DONE : ISSUE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath and registered outputs. The tester start is high only while in
    // ISSUE, so every candidate produces a fresh low-to-high edge, and the
    // tester done is first looked at one cycle after that edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand        <= '0;
            lim         <= '0;
            kth_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            count_q     <= '0;
            sum_q       <= '0;
            kth_prime_q <= '0;
            kth_found_q <= 1'b0;
            t_start     <= 1'b0;
            t_value     <= '0;
        end else begin
            cand    <= cand_d;
            busy_q  <= (state_next == ISSUE) || (state_next == WAIT) ||
                       (state_next == ACCUM);
            done_q  <= (state_next == DONE);
            t_start <= (state_next == ISSUE);
            if (state_next == ISSUE) begin
                t_value <= cand_d;
            end
            if (accept) begin
                lim         <= bus.limit;
                kth_q       <= bus.kth;
                count_q     <= '0;
                sum_q       <= '0;
                kth_prime_q <= '0;
                kth_found_q <= 1'b0;
            end else if (state == ACCUM && t_result) begin
                count_q <= count_inc;
                sum_q   <= sum_q + SUM_W'(cand);
                if (kth_q != '0 && count_inc == kth_q) begin
                    kth_prime_q <= cand;
                    kth_found_q <= 1'b1;
                end
            end
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.prime_count = count_q;
    assign bus.prime_sum   = sum_q;
    assign bus.kth_prime   = kth_prime_q;
    assign bus.kth_found   = kth_found_q;
endmodule
